lap_stopwatch: RTL and testbench

LAP_STOPWATCH -- requirements
Module: lap_stopwatch

---
 rtl/stopwatch_pkg.sv | 35 +++
 rtl/bcd_digit.sv | 32 +++
 rtl/lap_stopwatch.sv | 161 ++++++++++++++++
 tb/tb_lap_stopwatch.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared state codes, sel mode codes and 7-segment helpers for the lap stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] MODE_UP_ZERO = 2'b00;
    localparam logic [1:0] MODE_UP_LOAD = 2'b01;
    localparam logic [1:0] MODE_DN_NINE = 2'b10;
    localparam logic [1:0] MODE_DN_LOAD = 2'b11;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low gfedcba patterns, entry n shows digit n.
    localparam logic [9:0][6:0] SEG_LUT = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg7_decode(input logic [3:0] d);
        if (d > 4'd9) begin
            return SEG_BLANK;
        end
        return SEG_LUT[d];
    endfunction

    function automatic logic [3:0] clamp_bcd(input logic [3:0] n);
        return (n > 4'd9) ? 4'd9 : n;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit stepped up or down by a carry/borrow input.
module bcd_digit (
    input  logic [3:0] d,
    input  logic       down,
    input  logic       cin,
    output logic [3:0] q_c,
    output logic       cout_c
);

    always_comb begin
        q_c    = d;
        cout_c = 1'b0;
        if (cin) begin
            if (down) begin
                if (d == 4'd0) begin
                    q_c    = 4'd9;
                    cout_c = 1'b1;
                end else begin
                    q_c = d - 4'd1;
                end
            end else begin
                if (d == 4'd9) begin
                    q_c    = 4'd0;
                    cout_c = 1'b1;
                end else begin
                    q_c = d + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/lap_stopwatch.sv
// BCD up/down stopwatch with lap hold and a multiplexed 7-segment scan.
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int unsigned NDIG        = 4,
    parameter int unsigned LDIG        = 2,
    parameter int unsigned TICK_DIV    = 1000000,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                clk,
    input  logic                R,
    input  logic                P,
    input  logic                L,
    input  logic [4*LDIG-1:0]   load,
    input  logic [1:0]          sel,
    input  logic                wrap,
    output logic [4*NDIG-1:0]   count,
    output logic [NDIG-1:0]     an,
    output logic [6:0]          sseg,
    output logic [1:0]          cstate,
    output logic                done
);

    localparam int unsigned CW = 4 * NDIG;
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned RW = $clog2(REFRESH_DIV);
    localparam int unsigned IW = $clog2(NDIG);
    localparam logic [CW-1:0] ALL9 = {NDIG{4'h9}};

    state_t          state, state_nxt;
    logic            down_q;
    logic [PW-1:0]   presc;
    logic [RW-1:0]   rcnt;
    logic [IW-1:0]   idx;
    logic            lap_act;
    logic [CW-1:0]   lap_q;

    logic            tick_c;
    logic [NDIG-1:0] cin_c;
    logic [NDIG-1:0] cout_c;
    logic [CW-1:0]   cnt_nxt_c;
    logic [CW-1:0]   term_c;
    logic [CW-1:0]   start_c;
    logic [CW-1:0]   disp_c;
    logic [3:0]      digit_c;
    logic            wrap_ev_c;
    logic            hit_term_c;
    logic            lap_ev_c;

    assign tick_c   = (state == ST_RUN) && (presc == PW'(TICK_DIV - 1));
    assign term_c   = down_q ? '0 : ALL9;
    assign lap_ev_c = L && ((state == ST_RUN) || (state == ST_PAUSE));
    assign cstate   = state;

    // Lookahead carry: a digit steps when every lower digit is at its rollover value.
    always_comb begin
        logic run;
        cin_c = '0;
        run   = tick_c;
        for (int g = 0; g < int'(NDIG); g++) begin
            cin_c[g] = run;
            run      = run && (count[4*g +: 4] == (down_q ? 4'd0 : 4'd9));
        end
    end

    for (genvar g = 0; g < int'(NDIG); g++) begin : g_dig
        bcd_digit u_digit (
            .d      (count[4*g +: 4]),
            .down   (down_q),
            .cin    (cin_c[g]),
            .q_c    (cnt_nxt_c[4*g +: 4]),
            .cout_c (cout_c[g])
        );
    end

    // A full wrap rolls every digit over at once.
    assign wrap_ev_c  = &cout_c;
    assign hit_term_c = tick_c && !wrap && ((cnt_nxt_c == term_c) || wrap_ev_c);

    always_comb begin
        start_c = '0;
        case (sel)
            MODE_UP_ZERO: start_c = '0;
            MODE_DN_NINE: start_c = ALL9;
            default: begin
                for (int i = 0; i < int'(LDIG); i++) begin
                    start_c[4*(int'(NDIG) - int'(LDIG) + i) +: 4] = clamp_bcd(load[4*i +: 4]);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (R) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (P) state_nxt = ST_RUN;
            ST_RUN: begin
                if (hit_term_c) begin
                    state_nxt = ST_DONE;
                end else if (P) begin
                    state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: if (P) state_nxt = ST_RUN;
            ST_DONE:  state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign disp_c  = lap_act ? lap_q : count;
    assign digit_c = disp_c[4*idx +: 4];

    always_ff @(posedge clk) begin
        if (R) begin
            down_q  <= sel[1];
            count   <= start_c;
            presc   <= '0;
            rcnt    <= '0;
            idx     <= '0;
            lap_act <= 1'b0;
            lap_q   <= '0;
            an      <= '1;
            sseg    <= SEG_BLANK;
            done    <= 1'b0;
        end else begin
            done <= (state_nxt == ST_DONE);
            if (state == ST_RUN) begin
                presc <= tick_c ? '0 : presc + PW'(1);
            end
            // Without wrap a rollover freezes the count at the terminal value.
            if (tick_c && !(wrap_ev_c && !wrap)) begin
                count <= cnt_nxt_c;
            end
            if (lap_ev_c) begin
                if (lap_act) begin
                    lap_act <= 1'b0;
                end else begin
                    lap_act <= 1'b1;
                    lap_q   <= count;
                end
            end
            if (rcnt == RW'(REFRESH_DIV - 1)) begin
                rcnt <= '0;
                idx  <= (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
            end else begin
                rcnt <= rcnt + RW'(1);
            end
            an   <= ~(NDIG'(1) << idx);
            sseg <= seg7_decode(digit_c);
        end
    end

endmodule

// File: tb/tb_lap_stopwatch.sv
// Self-checking bench for lap_stopwatch against an arithmetic reference model.
module tb_lap_stopwatch;

    localparam int NDIG = 4;
    localparam int LDIG = 2;
    localparam int TICK_DIV = 2;
    localparam int REFRESH_DIV = 4;

    logic        clk = 1'b0;
    logic        R = 1'b1, P = 1'b0, L = 1'b0, wrap = 1'b0;
    logic [7:0]  load = 8'h00;
    logic [1:0]  sel = 2'b00;
    logic [15:0] count;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic [1:0]  cstate;
    logic        done;

    int errors = 0;
    int checks = 0;

    // Reference model: plain integers, states use the documented codes 0..3.
    int m_st, m_cnt, m_presc, m_rcnt, m_idx, m_lap;
    bit m_down, m_lapact;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic [6:0] segs [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    lap_stopwatch #(.NDIG(NDIG), .LDIG(LDIG), .TICK_DIV(TICK_DIV), .REFRESH_DIV(REFRESH_DIV)) dut (
        .clk(clk), .R(R), .P(P), .L(L), .load(load), .sel(sel), .wrap(wrap),
        .count(count), .an(an), .sseg(sseg), .cstate(cstate), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int clampd(input logic [3:0] n);
        return (n > 4'd9) ? 9 : int'(n);
    endfunction

    function automatic logic [15:0] bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model_edge();
        int disp, dig, nxt;
        bit tk;
        if (R) begin
            m_st = 0; m_down = sel[1]; m_presc = 0; m_rcnt = 0; m_idx = 0;
            m_lapact = 0; m_lap = 0; e_an = 4'hF; e_seg = 7'h7F;
            case (sel)
                2'b00: m_cnt = 0;
                2'b10: m_cnt = 9999;
                default: m_cnt = clampd(load[7:4]) * 1000 + clampd(load[3:0]) * 100;
            endcase
        end else begin
            disp = m_lapact ? m_lap : m_cnt;
            dig = disp;
            for (int i = 0; i < m_idx; i++) dig = dig / 10;
            dig = dig % 10;
            e_an = 4'hF & ~(4'd1 << m_idx);
            e_seg = segs[dig];
            tk = (m_st == 1) && (m_presc == TICK_DIV - 1);
            nxt = m_cnt;
            if (tk) nxt = m_down ? (m_cnt + 9999) % 10000 : (m_cnt + 1) % 10000;
            if (L && (m_st == 1 || m_st == 2)) begin
                if (m_lapact) m_lapact = 0;
                else begin m_lapact = 1; m_lap = m_cnt; end
            end
            if (m_st == 1) m_presc = tk ? 0 : m_presc + 1;
            case (m_st)
                0: if (P) m_st = 1;
                1: begin
                    if (tk && !wrap && nxt == (m_down ? 0 : 9999)) m_st = 3;
                    else if (P) m_st = 2;
                end
                2: if (P) m_st = 1;
                default: ;
            endcase
            m_cnt = nxt;
            if (m_rcnt == REFRESH_DIV - 1) begin
                m_rcnt = 0;
                m_idx = (m_idx + 1) % NDIG;
            end else begin
                m_rcnt++;
            end
        end
    endtask

    task automatic cyc(input bit p, input bit l);
        P = p; L = l;
        @(posedge clk);
        model_edge();
        #1;
        P = 1'b0; L = 1'b0;
    endtask

    task automatic do_reset(input logic [1:0] s, input logic [7:0] ld, input bit w);
        sel = s; load = ld; wrap = w; R = 1'b1;
        cyc(0, 0); cyc(0, 0);
        R = 1'b0;
    endtask

    task automatic test_reset();
        logic [1:0]  sv [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
        logic [7:0]  lv [4] = '{8'h55, 8'h00, 8'hAB, 8'h3F};
        logic [15:0] ev [4] = '{16'h0000, 16'h9999, 16'h9900, 16'h3900};
        for (int k = 0; k < 4; k++) begin
            sel = sv[k]; load = lv[k]; R = 1'b1;
            cyc(1, 1); cyc(0, 0);
            checks++; if (count !== ev[k]) begin errors++; $display("FAIL reset_count[%0d] got=%h exp=%h", k, count, ev[k]); end
            checks++; if (an !== 4'hF || sseg !== 7'h7F) begin errors++; $display("FAIL reset_disp got an=%b sseg=%h exp an=1111 sseg=7f", an, sseg); end
            checks++; if (cstate !== 2'b00 || done !== 1'b0) begin errors++; $display("FAIL reset_state got cstate=%b done=%b exp 00/0", cstate, done); end
        end
        R = 1'b0;
    endtask

    task automatic test_count_pause();
        do_reset(2'b00, 8'h00, 0);
        cyc(1, 0);
        for (int n = 0; n < 50 && m_cnt != 3; n++) cyc(0, 0);
        checks++; if (count !== 16'h0003 || cstate !== 2'b01) begin errors++; $display("FAIL run3 got count=%h cstate=%b exp 0003/01", count, cstate); end
        sel = 2'b10; load = 8'h77;
        cyc(1, 0);
        for (int n = 0; n < 20; n++) begin
            checks++; if (count !== 16'h0003 || cstate !== 2'b10) begin errors++; $display("FAIL pause_hold got count=%h cstate=%b exp 0003/10", count, cstate); end
            cyc(0, 0);
        end
    endtask

    task automatic test_up_done();
        do_reset(2'b01, 8'h99, 0);
        checks++; if (count !== 16'h9900) begin errors++; $display("FAIL up_start got=%h exp=9900", count); end
        cyc(1, 0);
        for (int n = 0; n < 1000 && m_st != 3; n++) begin
            cyc(0, 0);
            checks++; if (count !== bcd(m_cnt)) begin errors++; $display("FAIL up_count got=%h exp=%h", count, bcd(m_cnt)); end
        end
        checks++; if (count !== 16'h9999 || cstate !== 2'b11 || done !== 1'b1) begin errors++; $display("FAIL up_done got count=%h cstate=%b done=%b exp 9999/11/1", count, cstate, done); end
        cyc(1, 0); cyc(0, 0); cyc(0, 0);
        checks++; if (count !== 16'h9999 || cstate !== 2'b11 || done !== 1'b1) begin errors++; $display("FAIL done_ignore_p got count=%h cstate=%b done=%b exp 9999/11/1", count, cstate, done); end
    endtask

    task automatic test_down_wrap();
        int seen;
        do_reset(2'b10, 8'h00, 1);
        cyc(1, 0);
        seen = 0;
        for (int n = 0; n < 25000 && m_cnt != 0; n++) begin
            cyc(0, 0);
            if (count !== bcd(m_cnt)) seen++;
        end
        checks++; if (seen != 0 || count !== 16'h0000) begin errors++; $display("FAIL down_to_zero got=%h exp=0000 (%0d cycles off)", count, seen); end
        for (int n = 0; n < 10 && m_cnt != 9999; n++) cyc(0, 0);
        checks++; if (count !== 16'h9999 || cstate !== 2'b01 || done !== 1'b0) begin errors++; $display("FAIL down_wrap got count=%h cstate=%b done=%b exp 9999/01/0", count, cstate, done); end
    endtask

    task automatic test_down_done();
        do_reset(2'b11, 8'h01, 0);
        checks++; if (count !== 16'h0100) begin errors++; $display("FAIL dn_start got=%h exp=0100", count); end
        cyc(1, 0);
        for (int n = 0; n < 1000 && m_st != 3; n++) cyc(0, 0);
        checks++; if (count !== 16'h0000 || done !== 1'b1 || cstate !== 2'b11) begin errors++; $display("FAIL dn_done got count=%h done=%b cstate=%b exp 0000/1/11", count, done, cstate); end
    endtask

    task automatic test_lap();
        logic [6:0] want;
        do_reset(2'b00, 8'h00, 0);
        cyc(1, 0);
        for (int n = 0; n < 100 && m_cnt != 5; n++) cyc(0, 0);
        cyc(0, 1);
        for (int n = 0; n < 100 && m_cnt != 9; n++) begin
            cyc(0, 0);
            want = (an == 4'b1110) ? segs[5] : segs[0];
            checks++; if (sseg !== want || sseg !== e_seg) begin errors++; $display("FAIL lap_hold got sseg=%h exp=%h an=%b", sseg, want, an); end
        end
        checks++; if (count !== 16'h0009) begin errors++; $display("FAIL lap_live got=%h exp=0009", count); end
        cyc(0, 1);
        for (int n = 0; n < 16; n++) begin
            cyc(0, 0);
            checks++; if (sseg !== e_seg || an !== e_an) begin errors++; $display("FAIL lap_release got an=%b sseg=%h exp an=%b sseg=%h", an, sseg, e_an, e_seg); end
        end
    endtask

    task automatic test_reset_midrun();
        do_reset(2'b00, 8'h00, 0);
        cyc(1, 0);
        for (int n = 0; n < 200 && m_cnt != 42; n++) cyc(0, 0);
        cyc(0, 1);
        checks++; if (count !== 16'h0042) begin errors++; $display("FAIL midrun_pre got=%h exp=0042", count); end
        sel = 2'b01; load = 8'h12; R = 1'b1;
        cyc(1, 1);
        checks++; if (count !== 16'h1200 || cstate !== 2'b00 || an !== 4'hF) begin errors++; $display("FAIL midrun_reset got count=%h cstate=%b an=%b exp 1200/00/1111", count, cstate, an); end
        R = 1'b0;
        for (int n = 0; n < 16; n++) begin
            cyc(0, 0);
            checks++; if (sseg !== e_seg || count !== 16'h1200) begin errors++; $display("FAIL midrun_nolap got sseg=%h count=%h exp %h/1200", sseg, count, e_seg); end
        end
    endtask

    task automatic test_random();
        logic [1:0] s;
        logic [7:0] ld;
        for (int it = 0; it < 8; it++) begin
            s = 2'($urandom_range(0, 3));
            ld = 8'($urandom);
            if (it == 0) begin s = 2'b01; ld = 8'h99; end
            if (s == 2'b11 && ld == 8'h00) ld = 8'h01;
            do_reset(s, ld, bit'($urandom_range(0, 1)));
            for (int n = 0; n < 400; n++) begin
                if ($urandom_range(0, 31) == 0) begin sel = 2'($urandom); load = 8'($urandom); end
                cyc($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
                checks++;
                if (count !== bcd(m_cnt) || cstate !== 2'(m_st) || done !== (m_st == 3) || an !== e_an || sseg !== e_seg) begin
                    errors++;
                    $display("FAIL rand[%0d.%0d] got count=%h cs=%b dn=%b an=%b seg=%h exp %h/%b/%b/%b/%h",
                             it, n, count, cstate, done, an, sseg, bcd(m_cnt), 2'(m_st), m_st == 3, e_an, e_seg);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_pause();
        test_up_done();
        test_down_wrap();
        test_down_done();
        test_lap();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
